// File: rtl/sync_pkg.sv
// Shared definitions for the OFDM synchroniser datapath.
//   clog2       : ceiling log2, usable in parameter defaults
//   sum_width   : moving-sum width that cannot overflow for a given depth
//   clamp_delay : maps a requested delay into the legal range 1..max_depth
package sync_pkg;

  localparam int unsigned DEFAULT_DATA_W    = 32;
  localparam int unsigned DEFAULT_MAX_DEPTH = 400;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) begin
      r++;
    end
    return r;
  endfunction

  // Sum of max_depth signed samples needs clog2(max_depth) extra bits.
  function automatic int unsigned sum_width(input int unsigned data_w,
                                            input int unsigned max_depth);
    return data_w + clog2(max_depth);
  endfunction

  function automatic int unsigned clamp_delay(input int unsigned cfg,
                                              input int unsigned max_depth);
    if (cfg == 0) begin
      return 1;
    end else if (cfg > max_depth) begin
      return max_depth;
    end
    return cfg;
  endfunction

endpackage

// File: rtl/sdp_ram_rf.sv
// Simple dual-port RAM, synchronous read, read-first on address collision.
// Written in the plain template that synthesis maps onto block RAM.
//   clk   : clock
//   we    : write enable; waddr/wdata : write port
//   re    : read enable;  raddr       : read address
//   rdata : registered read data, valid the cycle after re
module sdp_ram_rf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 400,
  parameter int unsigned AW    = 9
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Both ports update with non-blocking assignments, so a read of the word
  // being written in the same cycle returns the old contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/delay_line_msum.sv
// Runtime-configurable delay line with moving sum over the delay window.
// Samples are stored in a circular RAM buffer; the sample leaving the window
// is read back as the new one is written, and the sum is updated by
// adding the new sample and subtracting the departing one.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous flush (state only, RAM untouched)
//   cfg_delay  : requested delay, latched on reset or clr, clamped to 1..MAX_DEPTH
//   s_valid    : input strobe, s_data : signed input sample
//   m_valid    : output strobe, 2 cycles after s_valid
//   m_data     : sample delayed by D accepted samples (0 until primed)
//   m_sum      : sum of the last D accepted samples
//   primed     : D samples accepted since the last reset/clr
module delay_line_msum
  import sync_pkg::*;
#(
  parameter int unsigned DATA_W    = DEFAULT_DATA_W,
  parameter int unsigned MAX_DEPTH = DEFAULT_MAX_DEPTH,
  parameter int unsigned AW        = clog2(MAX_DEPTH + 1),
  parameter int unsigned SUM_W     = sum_width(DATA_W, MAX_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [AW-1:0]     cfg_delay,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic [SUM_W-1:0]  m_sum,
  output logic              primed
);

  localparam int unsigned RAM_AW = (MAX_DEPTH > 1) ? clog2(MAX_DEPTH) : 1;
  // One extra bit so wp + MAX_DEPTH cannot wrap before the subtraction.
  localparam int unsigned PW     = AW + 1;

  logic [AW-1:0]     delay_q, delay_d;
  logic [AW-1:0]     wp_q, wp_d;
  logic [AW-1:0]     fill_q, fill_d;
  logic              flush;
  logic              accept;
  logic [PW-1:0]     rd_full;
  logic [RAM_AW-1:0] rd_addr;
  logic [RAM_AW-1:0] wr_addr;

  // Stage 1 registers
  logic              v1_q;
  logic [DATA_W-1:0] x0_q;
  logic              old_ok_q;
  logic [DATA_W-1:0] ram_q;
  logic [DATA_W-1:0] xold;

  // Stage 2 registers
  logic              m_valid_q;
  logic [DATA_W-1:0] m_data_q;
  logic [SUM_W-1:0]  m_sum_q, sum_next;
  logic              primed_q, primed_d;

  assign flush  = !rst_n || clr;
  assign accept = s_valid && !flush;

  always_comb begin
    rd_full = '0;
    if (wp_q >= delay_q) begin
      rd_full = {1'b0, wp_q} - {1'b0, delay_q};
    end else begin
      rd_full = {1'b0, wp_q} + PW'(MAX_DEPTH) - {1'b0, delay_q};
    end
  end

  assign rd_addr = RAM_AW'(rd_full);
  assign wr_addr = RAM_AW'(wp_q);

  always_comb begin
    delay_d  = delay_q;
    wp_d     = wp_q;
    fill_d   = fill_q;
    if (flush) begin
      delay_d = AW'(clamp_delay(int'(cfg_delay), MAX_DEPTH));
      wp_d    = '0;
      fill_d  = '0;
    end else if (accept) begin
      wp_d = (wp_q == AW'(MAX_DEPTH - 1)) ? '0 : wp_q + AW'(1);
      if (fill_q != delay_q) begin
        fill_d = fill_q + AW'(1);
      end
    end
    primed_d = !flush && (fill_d == delay_q);
  end

  sdp_ram_rf #(
    .WIDTH (DATA_W),
    .DEPTH (MAX_DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_addr),
    .wdata (s_data),
    .re    (accept),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // Until the window has filled, the RAM word at rd may be stale data from
  // before a reset/clr, so it is masked to zero.
  assign xold     = old_ok_q ? ram_q : '0;
  assign sum_next = m_sum_q + SUM_W'($signed(x0_q)) - SUM_W'($signed(xold));

  always_ff @(posedge clk) begin
    delay_q  <= delay_d;
    wp_q     <= wp_d;
    fill_q   <= fill_d;
    primed_q <= primed_d;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      v1_q     <= 1'b0;
      x0_q     <= '0;
      old_ok_q <= 1'b0;
    end else begin
      v1_q <= accept;
      if (accept) begin
        x0_q     <= s_data;
        old_ok_q <= (fill_q == delay_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sum_q   <= '0;
    end else begin
      m_valid_q <= v1_q;
      if (v1_q) begin
        m_data_q <= xold;
        m_sum_q  <= sum_next;
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_sum   = m_sum_q;
  assign primed  = primed_q;

endmodule

// File: tb/tb_delay_line_msum.sv
module tb_delay_line_msum;

  localparam int DW  = 16;
  localparam int AW8 = 4;
  localparam int AW5 = 3;
  localparam int SW  = DW + 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           clr = 1'b0;
  logic           s_valid = 1'b0;
  logic [DW-1:0]  s_data = '0;
  logic [AW8-1:0] cfg8 = '0;
  logic [AW5-1:0] cfg5 = '0;

  logic           m_valid8, primed8, m_valid5, primed5;
  logic [DW-1:0]  m_data8, m_data5;
  logic [SW-1:0]  m_sum8, m_sum5;

  always #5 clk = ~clk;

  delay_line_msum #(.DATA_W(DW), .MAX_DEPTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .cfg_delay (cfg8),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .m_valid   (m_valid8),
    .m_data    (m_data8),
    .m_sum     (m_sum8),
    .primed    (primed8)
  );

  delay_line_msum #(.DATA_W(DW), .MAX_DEPTH(5)) u_dut5 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .cfg_delay (cfg5),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .m_valid   (m_valid5),
    .m_data    (m_data5),
    .m_sum     (m_sum5),
    .primed    (primed5)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // History of accepted samples; delay D means "output the sample D places
  // back, sum the most recent D".
  int hist[$];
  int nacc;
  int cyc = 0;
  int maxd[2] = '{8, 5};
  int dd[2];
  int ev[2], ed[2], es[2], ep[2];

  typedef struct {
    int due;
    int d0, s0, d1, s1;
  } pend_t;
  pend_t pend[$];

  function automatic int clampd(input int c, input int m);
    if (c < 1) return 1;
    if (c > m) return m;
    return c;
  endfunction

  function automatic int win_data(input int d);
    int n = hist.size();
    return (nacc > d) ? hist[n - 1 - d] : 0;
  endfunction

  function automatic int win_sum(input int d);
    int n = hist.size();
    int s = 0;
    for (int i = 0; i < d && i < nacc; i++) s += hist[n - 1 - i];
    return s;
  endfunction

  always @(posedge clk) begin
    pend_t p;
    cyc++;
    if (!rst_n || clr) begin
      hist.delete();
      pend.delete();
      nacc  = 0;
      dd[0] = clampd(int'(cfg8), maxd[0]);
      dd[1] = clampd(int'(cfg5), maxd[1]);
      for (int k = 0; k < 2; k++) begin
        ev[k] = 0; ed[k] = 0; es[k] = 0; ep[k] = 0;
      end
    end else begin
      ev[0] = 0;
      ev[1] = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        p = pend.pop_front();
        ev[0] = 1; ed[0] = p.d0; es[0] = p.s0;
        ev[1] = 1; ed[1] = p.d1; es[1] = p.s1;
      end
      if (s_valid) begin
        hist.push_back(int'($signed(s_data)));
        nacc++;
        if (hist.size() > 32) void'(hist.pop_front());
        p.due = cyc + 1;
        p.d0 = win_data(dd[0]); p.s0 = win_sum(dd[0]);
        p.d1 = win_data(dd[1]); p.s1 = win_sum(dd[1]);
        pend.push_back(p);
      end
      ep[0] = (nacc >= dd[0]) ? 1 : 0;
      ep[1] = (nacc >= dd[1]) ? 1 : 0;
    end
  end

  // ---------------- monitor ----------------
  int obs_d[2][$];
  int obs_s[2][$];

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid8", {31'b0, m_valid8}, ev[0]);
      chk("data8", $signed(m_data8), ed[0]);
      chk("sum8", $signed(m_sum8), es[0]);
      chk("primed8", {31'b0, primed8}, ep[0]);
      chk("valid5", {31'b0, m_valid5}, ev[1]);
      chk("data5", $signed(m_data5), ed[1]);
      chk("sum5", $signed(m_sum5), es[1]);
      chk("primed5", {31'b0, primed5}, ep[1]);
      if (m_valid8 === 1'b1) begin
        obs_d[0].push_back(int'($signed(m_data8)));
        obs_s[0].push_back(int'($signed(m_sum8)));
      end
      if (m_valid5 === 1'b1) begin
        obs_d[1].push_back(int'($signed(m_data5)));
        obs_s[1].push_back(int'($signed(m_sum5)));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    int d;
    int exp_data;
    int exp_sum;
  } vec_t;

  int te_d[$];
  int te_s[$];

  task automatic clear_obs();
    for (int k = 0; k < 2; k++) begin
      obs_d[k].delete();
      obs_s[k].delete();
    end
  endtask

  task automatic set_cfg(input int c);
    cfg8 = AW8'(c);
    cfg5 = (c > 7) ? 3'd7 : AW5'(c);
  endtask

  task automatic do_reset(input int c);
    rst_n = 1'b0;
    set_cfg(c);
    @(posedge clk); @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_obs();
  endtask

  task automatic feed(input int d, input int gaps);
    s_valid = 1'b1;
    s_data  = DW'(d);
    @(posedge clk); #1;
    s_valid = 1'b0;
    for (int g = 0; g < gaps; g++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_obs(input string nm, input int w);
    logic signed [31:0] gd, gs;
    chk({nm, " count"}, obs_d[w].size(), te_d.size());
    for (int i = 0; i < te_d.size(); i++) begin
      gd = 'x;
      gs = 'x;
      if (i < obs_d[w].size()) begin
        gd = obs_d[w][i];
        gs = obs_s[w][i];
      end
      chk({nm, " m_data"}, gd, te_d[i]);
      chk({nm, " m_sum"}, gs, te_s[i]);
    end
  endtask

  // ---------------- test sequence ----------------
  vec_t basic[5];
  vec_t full[10];
  vec_t neg[12];
  vec_t c7[5];
  vec_t d1[3];

  initial begin
    basic = '{'{1, 0, 1}, '{2, 0, 3}, '{3, 0, 6}, '{4, 1, 9}, '{5, 2, 12}};
    full  = '{'{1, 0, 1}, '{2, 0, 3}, '{3, 0, 6}, '{4, 0, 10}, '{5, 0, 15},
              '{6, 0, 21}, '{7, 0, 28}, '{8, 0, 36}, '{9, 1, 44}, '{10, 2, 52}};
    for (int i = 0; i < 12; i++) begin
      neg[i].d        = -3;
      neg[i].exp_data = (i < 5) ? 0 : -3;
      neg[i].exp_sum  = -3 * ((i < 5) ? i + 1 : 5);
    end
    c7 = '{'{7, 0, 7}, '{7, 0, 14}, '{7, 0, 21}, '{7, 0, 28}, '{7, 7, 28}};
    d1 = '{'{1, 0, 1}, '{2, 1, 2}, '{3, 2, 3}};

    rst_n = 1'b0;
    set_cfg(3);
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Basic back-to-back, D=3
    do_reset(3);
    for (int i = 0; i < 5; i++) feed(basic[i].d, 0);
    idle(3);
    te_d.delete(); te_s.delete();
    for (int i = 0; i < 5; i++) begin
      te_d.push_back(basic[i].exp_data); te_s.push_back(basic[i].exp_sum);
    end
    check_obs("basic8", 0);
    check_obs("basic5", 1);

    // Gapped: same values expected, timing covered by the model
    do_reset(3);
    for (int i = 0; i < 5; i++) feed(basic[i].d, 2);
    idle(3);
    check_obs("gap8", 0);
    check_obs("gap5", 1);

    // Full depth read-first, D=8
    do_reset(8);
    for (int i = 0; i < 10; i++) feed(full[i].d, 0);
    idle(3);
    te_d.delete(); te_s.delete();
    for (int i = 0; i < 10; i++) begin
      te_d.push_back(full[i].exp_data); te_s.push_back(full[i].exp_sum);
    end
    check_obs("full8", 0);

    // Clamp above max: cfg 9 behaves as D=8
    do_reset(9);
    for (int i = 0; i < 10; i++) feed(full[i].d, 0);
    idle(3);
    check_obs("clamp_hi8", 0);

    // Signed, non-power-of-two depth, D=5
    do_reset(5);
    for (int i = 0; i < 12; i++) feed(neg[i].d, 0);
    idle(3);
    te_d.delete(); te_s.delete();
    for (int i = 0; i < 12; i++) begin
      te_d.push_back(neg[i].exp_data); te_s.push_back(neg[i].exp_sum);
    end
    check_obs("neg5", 1);
    check_obs("neg8", 0);

    // clr mid-stream with stale RAM; clr-cycle sample dropped
    do_reset(3);
    for (int i = 0; i < 10; i++) feed(100 + i, 0);
    clr     = 1'b1;
    s_valid = 1'b1;
    s_data  = DW'(99);
    set_cfg(4);
    @(posedge clk); #1;
    clr     = 1'b0;
    s_valid = 1'b0;
    clear_obs();
    set_cfg(2);
    for (int i = 0; i < 5; i++) feed(c7[i].d, 0);
    idle(3);
    te_d.delete(); te_s.delete();
    for (int i = 0; i < 5; i++) begin
      te_d.push_back(c7[i].exp_data); te_s.push_back(c7[i].exp_sum);
    end
    check_obs("clr8", 0);
    check_obs("clr5", 1);

    // Clamp zero: cfg 0 behaves as D=1
    do_reset(0);
    for (int i = 0; i < 3; i++) feed(d1[i].d, 0);
    idle(3);
    te_d.delete(); te_s.delete();
    for (int i = 0; i < 3; i++) begin
      te_d.push_back(d1[i].exp_data); te_s.push_back(d1[i].exp_sum);
    end
    check_obs("clamp0_8", 0);
    check_obs("clamp0_5", 1);

    // Randomized traffic against the model
    for (int r = 0; r < 8; r++) begin
      do_reset(int'($urandom_range(0, 15)));
      for (int c = 0; c < 200; c++) begin
        s_valid = ($urandom_range(0, 9) < 7);
        s_data  = DW'($urandom);
        cfg8    = AW8'($urandom);
        cfg5    = AW5'($urandom);
        clr     = ($urandom_range(0, 63) == 0);
        @(posedge clk); #1;
        clr     = 1'b0;
      end
      s_valid = 1'b0;
      idle(3);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
